// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM
// state encoding, datapath mux/ALU select encodings and the control word.
package riscv_ctrl_pkg;

    // Major opcodes (instruction bits [6:0]) handled by the controller
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Controller states; the encoding is visible on state_o for debug
    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_LUI      = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_WB_ALU   = 4'd9,
        ST_WB_MEM   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JAL      = 4'd12,
        ST_ERROR    = 4'd13
    } state_t;

    // ALUOp encodings (2'b01 is reserved and never driven)
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_BRANCH = 2'b11;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_ZERO  = 2'b10;
    localparam logic [1:0] SRCA_OLDPC = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // Register write-back source select
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // Datapath control word produced by the output decoder
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
    } ctrl_t;

    // States that hold a memory request until mem_ready is seen
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait state and flags the
// cycle on which the allowed budget runs out (MEM_WAIT_MAX = 0 never expires).
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    input  logic mem_ready,
    output logic expire
);

    localparam int              CNT_BITS = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(MEM_WAIT_MAX - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    logic [CNT_BITS-1:0] wait_cnt_r;

    // Wait counter: cleared on entry and on completion, bumped on each stall cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (clear) begin
            wait_cnt_r <= '0;
        end else if (waiting) begin
            if (mem_ready) begin
                wait_cnt_r <= '0;
            end else begin
                wait_cnt_r <= wait_cnt_r + CNT_ONE;
            end
        end
    end

    // Expire when the stall about to be counted is the last one allowed
    always_comb begin
        expire = 1'b0;
        if ((MEM_WAIT_MAX != 0) && waiting && !mem_ready && (wait_cnt_r == LAST_CNT)) begin
            expire = 1'b1;
        end else begin
            expire = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I sequencing controller: one shared memory port and one ALU
// driven through fetch/decode/execute/memory/write-back, with a memory
// handshake timeout and a retired-instruction counter.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       MemToReg,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             PCSource,
    output logic             illegal_op,
    output logic             error,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_o
);

    localparam logic [CNT_W-1:0] INSTRET_ONE = CNT_W'(1);

    state_t           state_r;
    state_t           next_s;
    logic             retire_s;
    logic             illegal_s;
    logic             waiting_s;
    logic             clear_s;
    logic             expire_s;
    ctrl_t            ctrl_s;
    logic [CNT_W-1:0] instret_r;

    assign waiting_s = is_wait_state(state_r);
    // Restart the stall count whenever a wait state is freshly entered
    assign clear_s   = is_wait_state(next_s) && (next_s != state_r);

    mem_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_mem_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_s),
        .waiting   (waiting_s),
        .mem_ready (mem_ready),
        .expire    (expire_s)
    );

    // State register; reset aborts any instruction immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RESET;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state selection plus retire and illegal-opcode indications
    always_comb begin
        next_s    = state_r;
        retire_s  = 1'b0;
        illegal_s = 1'b0;
        case (state_r)
            ST_RESET: next_s = ST_FETCH;
            ST_FETCH: begin
                if (expire_s) begin
                    next_s = ST_ERROR;
                end else if (mem_ready) begin
                    next_s = ST_DECODE;
                end else begin
                    next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:          next_s = ST_EXEC_R;
                    OP_ITYPE:          next_s = ST_EXEC_I;
                    OP_LOAD, OP_STORE: next_s = ST_MEM_ADDR;
                    OP_BRANCH:         next_s = ST_BRANCH;
                    OP_JAL:            next_s = ST_JAL;
                    OP_LUI:            next_s = ST_LUI;
                    default: begin
                        next_s    = ST_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R, ST_EXEC_I, ST_LUI: next_s = ST_WB_ALU;
            ST_MEM_ADDR: begin
                if (opcode == OP_LOAD) begin
                    next_s = ST_MEM_RD;
                end else begin
                    next_s = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                if (expire_s) begin
                    next_s = ST_ERROR;
                end else if (mem_ready) begin
                    next_s = ST_WB_MEM;
                end else begin
                    next_s = ST_MEM_RD;
                end
            end
            ST_MEM_WR: begin
                if (expire_s) begin
                    next_s = ST_ERROR;
                end else if (mem_ready) begin
                    next_s   = ST_FETCH;
                    retire_s = 1'b1;
                end else begin
                    next_s = ST_MEM_WR;
                end
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JAL: begin
                next_s   = ST_FETCH;
                retire_s = 1'b1;
            end
            ST_ERROR: next_s = ST_ERROR;
            // Unused encodings are treated as a fault and parked in ERROR
            default:  next_s = ST_ERROR;
        endcase
    end

    // Moore control decode; only the PC/IR write enables look at inputs
    always_comb begin
        ctrl_s = '0;
        case (state_r)
            ST_FETCH: begin
                ctrl_s.iord      = 1'b0;
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.alu_src_a = SRCA_PC;
                ctrl_s.alu_src_b = SRCB_FOUR;
                ctrl_s.alu_op    = ALUOP_ADD;
                ctrl_s.pc_source = 1'b0;
                ctrl_s.ir_write  = mem_ready;
                ctrl_s.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl_s.alu_src_a = SRCA_OLDPC;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_op    = ALUOP_ADD;
            end
            ST_EXEC_R: begin
                ctrl_s.alu_src_a = SRCA_RS1;
                ctrl_s.alu_src_b = SRCB_RS2;
                ctrl_s.alu_op    = ALUOP_FUNCT;
            end
            ST_EXEC_I: begin
                ctrl_s.alu_src_a = SRCA_RS1;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_op    = ALUOP_FUNCT;
            end
            ST_LUI: begin
                ctrl_s.alu_src_a = SRCA_ZERO;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                ctrl_s.alu_src_a = SRCA_RS1;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                ctrl_s.iord     = 1'b1;
                ctrl_s.mem_read = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_s.iord      = 1'b1;
                ctrl_s.mem_write = 1'b1;
            end
            ST_WB_ALU: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = WB_ALUOUT;
            end
            ST_WB_MEM: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = WB_MDR;
            end
            ST_BRANCH: begin
                ctrl_s.alu_src_a = SRCA_RS1;
                ctrl_s.alu_src_b = SRCB_RS2;
                ctrl_s.alu_op    = ALUOP_BRANCH;
                ctrl_s.pc_source = 1'b1;
                ctrl_s.pc_write  = branch_taken;
            end
            ST_JAL: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = WB_PC;
                ctrl_s.pc_write   = 1'b1;
                ctrl_s.pc_source  = 1'b1;
            end
            default: ctrl_s = '0;
        endcase
    end

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_r <= '0;
        end else if (retire_s) begin
            instret_r <= instret_r + INSTRET_ONE;
        end
    end

    assign PCWrite    = ctrl_s.pc_write;
    assign IRWrite    = ctrl_s.ir_write;
    assign IorD       = ctrl_s.iord;
    assign MemRead    = ctrl_s.mem_read;
    assign MemWrite   = ctrl_s.mem_write;
    assign RegWrite   = ctrl_s.reg_write;
    assign MemToReg   = ctrl_s.mem_to_reg;
    assign ALUSrcA    = ctrl_s.alu_src_a;
    assign ALUSrcB    = ctrl_s.alu_src_b;
    assign ALUOp      = ctrl_s.alu_op;
    assign PCSource   = ctrl_s.pc_source;
    assign illegal_op = illegal_s;
    assign error      = (state_r == ST_ERROR);
    assign instret    = instret_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against an instruction-level
// reference model kept here.
module tb_multicycle_ctrl_fsm;
    import riscv_ctrl_pkg::*;

    localparam int WAIT_MAX = 4;
    localparam int CW       = 4;

    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_LD  = 7'b0000011;
    localparam logic [6:0] T_ST  = 7'b0100011;
    localparam logic [6:0] T_BR  = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_LUI = 7'b0110111;
    localparam logic [6:0] T_ILL = 7'b1111111;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    opcode;
    logic          branch_taken;
    logic          mem_ready;
    logic          PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite;
    logic [1:0]    MemToReg, ALUSrcA, ALUSrcB, ALUOp;
    logic          PCSource, illegal_op, error;
    logic [CW-1:0] instret;
    logic [3:0]    state_o;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.MEM_WAIT_MAX(WAIT_MAX), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .error(error),
        .instret(instret), .state_o(state_o)
    );

    int checks = 0;
    int passes = 0;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (instruction level) ----------------
    state_t m_st;
    state_t m_plan[$];
    int     m_miss;
    int     m_instret;

    function automatic bit legal_op(input logic [6:0] op);
        return op inside {T_R, T_I, T_LD, T_ST, T_BR, T_JAL, T_LUI};
    endfunction

    function automatic bit mem_wait(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

    // {PCWrite,IRWrite,IorD,MemRead,MemWrite,RegWrite,MemToReg,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal_op,error}
    function automatic logic [16:0] exp_ctrl(input state_t s, input logic [6:0] op,
                                             input logic bt, input logic mr);
        logic pcw, irw, iord, mrd, mwr, rw, pcs, ill, err;
        logic [1:0] m2r, sa, sb, aop;
        {pcw, irw, iord, mrd, mwr, rw, pcs, ill, err} = 9'b0;
        {m2r, sa, sb, aop} = 8'b0;
        case (s)
            ST_FETCH:    begin mrd = 1'b1; sb = 2'b01; pcw = mr; irw = mr; end
            ST_DECODE:   begin sa = 2'b11; sb = 2'b10; ill = !legal_op(op); end
            ST_EXEC_R:   begin sa = 2'b01; aop = 2'b10; end
            ST_EXEC_I:   begin sa = 2'b01; sb = 2'b10; aop = 2'b10; end
            ST_LUI:      begin sa = 2'b10; sb = 2'b10; end
            ST_MEM_ADDR: begin sa = 2'b01; sb = 2'b10; end
            ST_MEM_RD:   begin iord = 1'b1; mrd = 1'b1; end
            ST_MEM_WR:   begin iord = 1'b1; mwr = 1'b1; end
            ST_WB_ALU:   rw = 1'b1;
            ST_WB_MEM:   begin rw = 1'b1; m2r = 2'b01; end
            ST_BRANCH:   begin sa = 2'b01; aop = 2'b11; pcs = 1'b1; pcw = bt; end
            ST_JAL:      begin rw = 1'b1; m2r = 2'b10; pcw = 1'b1; pcs = 1'b1; end
            ST_ERROR:    err = 1'b1;
            default:     ;
        endcase
        return {pcw, irw, iord, mrd, mwr, rw, m2r, sa, sb, aop, pcs, ill, err};
    endfunction

    task automatic model_reset();
        m_st = ST_RESET;
        m_plan.delete();
        m_miss = 0;
        m_instret = 0;
    endtask

    // Advance the model across one clock edge with the inputs of this cycle
    task automatic model_advance(input logic rst, input logic [6:0] op, input logic mr);
        if (rst) begin model_reset(); return; end
        if (m_st == ST_ERROR) return;
        if (m_st == ST_RESET) begin m_st = ST_FETCH; m_miss = 0; return; end
        if (mem_wait(m_st) && !mr) begin
            m_miss++;
            if (WAIT_MAX != 0 && m_miss == WAIT_MAX) m_st = ST_ERROR;
            return;
        end
        m_miss = 0;
        if (m_st == ST_FETCH) begin
            m_st = ST_DECODE;
        end else if (m_st == ST_DECODE) begin
            m_plan.delete();
            case (op)
                T_R:   begin m_plan.push_back(ST_EXEC_R); m_plan.push_back(ST_WB_ALU); end
                T_I:   begin m_plan.push_back(ST_EXEC_I); m_plan.push_back(ST_WB_ALU); end
                T_LUI: begin m_plan.push_back(ST_LUI);    m_plan.push_back(ST_WB_ALU); end
                T_LD:  begin m_plan.push_back(ST_MEM_ADDR); m_plan.push_back(ST_MEM_RD);
                             m_plan.push_back(ST_WB_MEM); end
                T_ST:  begin m_plan.push_back(ST_MEM_ADDR); m_plan.push_back(ST_MEM_WR); end
                T_BR:  m_plan.push_back(ST_BRANCH);
                T_JAL: m_plan.push_back(ST_JAL);
                default: ;
            endcase
            if (m_plan.size() == 0) m_st = ST_FETCH;
            else m_st = m_plan.pop_front();
        end else if (m_plan.size() != 0) begin
            m_st = m_plan.pop_front();
        end else begin
            m_st = ST_FETCH;
            m_instret = (m_instret + 1) % (1 << CW);
        end
    endtask

    // One clock cycle: drive at negedge, compare to the model, then advance it
    task automatic step(input logic rst, input logic [6:0] op, input logic bt, input logic mr);
        @(negedge clk);
        reset = rst; opcode = op; branch_taken = bt; mem_ready = mr;
        if (rst) model_reset();
        #1;
        check_val("model_ctrl",
                  32'({PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemToReg,
                       ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, error}),
                  32'(exp_ctrl(m_st, op, bt, mr)));
        check_val("model_state", 32'(state_o), 32'(m_st));
        check_val("model_instret", 32'(instret), 32'(m_instret));
        model_advance(rst, op, mr);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       bt;
        logic       mr;
        state_t     est;
        logic [7:0] eflags;   // {PCWrite,IRWrite,IorD,MemRead,MemWrite,RegWrite,illegal_op,error}
        int         ein;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic rst, input logic [6:0] op, input logic bt,
                                 input logic mr, input state_t est, input logic [7:0] ef,
                                 input int ein);
        vec_t v;
        v.rst = rst; v.op = op; v.bt = bt; v.mr = mr; v.est = est; v.eflags = ef; v.ein = ein;
        return v;
    endfunction

    localparam logic [7:0] F_FETCH = 8'b1101_0000;
    localparam logic [7:0] F_NONE  = 8'b0000_0000;
    localparam logic [7:0] F_WB    = 8'b0000_0100;

    logic [6:0] cur_op;
    logic       r_rst, r_bt, r_mr;

    initial begin
        reset = 1'b1; opcode = 7'd0; branch_taken = 1'b0; mem_ready = 1'b0;
        model_reset();

        tbl.push_back(mkv(1'b1, T_R,   1'b0, 1'b1, ST_RESET,    F_NONE, 0));
        tbl.push_back(mkv(1'b0, T_R,   1'b0, 1'b1, ST_RESET,    F_NONE, 0));
        tbl.push_back(mkv(1'b0, T_R,   1'b0, 1'b1, ST_FETCH,    F_FETCH, 0));
        tbl.push_back(mkv(1'b0, T_R,   1'b0, 1'b1, ST_DECODE,   F_NONE, 0));
        tbl.push_back(mkv(1'b0, T_R,   1'b0, 1'b1, ST_EXEC_R,   F_NONE, 0));
        tbl.push_back(mkv(1'b0, T_R,   1'b0, 1'b1, ST_WB_ALU,   F_WB,   0));
        tbl.push_back(mkv(1'b0, T_LD,  1'b0, 1'b1, ST_FETCH,    F_FETCH, 1));
        tbl.push_back(mkv(1'b0, T_LD,  1'b0, 1'b1, ST_DECODE,   F_NONE, 1));
        tbl.push_back(mkv(1'b0, T_LD,  1'b0, 1'b1, ST_MEM_ADDR, F_NONE, 1));
        tbl.push_back(mkv(1'b0, T_LD,  1'b0, 1'b0, ST_MEM_RD,   8'b0011_0000, 1));
        tbl.push_back(mkv(1'b0, T_LD,  1'b0, 1'b0, ST_MEM_RD,   8'b0011_0000, 1));
        tbl.push_back(mkv(1'b0, T_LD,  1'b0, 1'b0, ST_MEM_RD,   8'b0011_0000, 1));
        tbl.push_back(mkv(1'b0, T_LD,  1'b0, 1'b1, ST_MEM_RD,   8'b0011_0000, 1));
        tbl.push_back(mkv(1'b0, T_LD,  1'b0, 1'b1, ST_WB_MEM,   F_WB,   1));
        tbl.push_back(mkv(1'b0, T_BR,  1'b1, 1'b1, ST_FETCH,    F_FETCH, 2));
        tbl.push_back(mkv(1'b0, T_BR,  1'b1, 1'b1, ST_DECODE,   F_NONE, 2));
        tbl.push_back(mkv(1'b0, T_BR,  1'b1, 1'b1, ST_BRANCH,   8'b1000_0000, 2));
        tbl.push_back(mkv(1'b0, T_BR,  1'b0, 1'b1, ST_FETCH,    F_FETCH, 3));
        tbl.push_back(mkv(1'b0, T_BR,  1'b0, 1'b1, ST_DECODE,   F_NONE, 3));
        tbl.push_back(mkv(1'b0, T_BR,  1'b0, 1'b1, ST_BRANCH,   F_NONE, 3));
        tbl.push_back(mkv(1'b0, T_ILL, 1'b0, 1'b1, ST_FETCH,    F_FETCH, 4));
        tbl.push_back(mkv(1'b0, T_ILL, 1'b0, 1'b1, ST_DECODE,   8'b0000_0010, 4));
        tbl.push_back(mkv(1'b0, T_ST,  1'b0, 1'b0, ST_FETCH,    8'b0001_0000, 4));
        tbl.push_back(mkv(1'b0, T_ST,  1'b0, 1'b1, ST_FETCH,    F_FETCH, 4));
        tbl.push_back(mkv(1'b0, T_ST,  1'b0, 1'b1, ST_DECODE,   F_NONE, 4));
        tbl.push_back(mkv(1'b0, T_ST,  1'b0, 1'b0, ST_MEM_ADDR, F_NONE, 4));
        tbl.push_back(mkv(1'b0, T_ST,  1'b0, 1'b1, ST_MEM_WR,   8'b0010_1000, 4));
        tbl.push_back(mkv(1'b0, T_JAL, 1'b0, 1'b1, ST_FETCH,    F_FETCH, 5));
        tbl.push_back(mkv(1'b0, T_JAL, 1'b0, 1'b1, ST_DECODE,   F_NONE, 5));
        tbl.push_back(mkv(1'b0, T_JAL, 1'b0, 1'b0, ST_JAL,      8'b1000_0100, 5));
        tbl.push_back(mkv(1'b0, T_LUI, 1'b0, 1'b1, ST_FETCH,    F_FETCH, 6));
        tbl.push_back(mkv(1'b0, T_LUI, 1'b0, 1'b0, ST_DECODE,   F_NONE, 6));
        tbl.push_back(mkv(1'b0, T_LUI, 1'b0, 1'b0, ST_LUI,      F_NONE, 6));
        tbl.push_back(mkv(1'b0, T_LUI, 1'b0, 1'b1, ST_WB_ALU,   F_WB,   6));
        tbl.push_back(mkv(1'b0, T_I,   1'b0, 1'b1, ST_FETCH,    F_FETCH, 7));
        tbl.push_back(mkv(1'b0, T_I,   1'b0, 1'b1, ST_DECODE,   F_NONE, 7));
        tbl.push_back(mkv(1'b0, T_I,   1'b0, 1'b1, ST_EXEC_I,   F_NONE, 7));
        tbl.push_back(mkv(1'b0, T_I,   1'b0, 1'b1, ST_WB_ALU,   F_WB,   7));
        tbl.push_back(mkv(1'b0, T_R,   1'b0, 1'b1, ST_FETCH,    F_FETCH, 8));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].op, tbl[i].bt, tbl[i].mr);
            check_val($sformatf("tbl%0d_state", i), 32'(state_o), 32'(tbl[i].est));
            check_val($sformatf("tbl%0d_flags", i),
                      32'({PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, illegal_op, error}),
                      32'(tbl[i].eflags));
            check_val($sformatf("tbl%0d_instret", i), 32'(instret), 32'(tbl[i].ein));
        end

        // Fetch timeout: four stalled FETCH cycles, then sticky ERROR
        step(1'b1, T_R, 1'b0, 1'b0);
        step(1'b0, T_R, 1'b0, 1'b0);
        for (int i = 0; i < WAIT_MAX; i++) begin
            step(1'b0, T_R, 1'b0, 1'b0);
            check_val("to_fetch_state", 32'(state_o), 32'(ST_FETCH));
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, T_R, 1'b0, 1'(i % 2));
            check_val("to_error_hold", 32'(error), 32'd1);
            check_val("to_error_state", 32'(state_o), 32'(ST_ERROR));
        end
        step(1'b1, T_R, 1'b0, 1'b1);
        check_val("to_reset_error", 32'(error), 32'd0);
        check_val("to_reset_state", 32'(state_o), 32'(ST_RESET));
        step(1'b0, T_R, 1'b0, 1'b1);
        step(1'b0, T_R, 1'b0, 1'b1);
        check_val("to_restart_fetch", 32'(state_o), 32'(ST_FETCH));

        // Reset arriving mid-write-wait must drop MemWrite without a clock edge
        step(1'b1, T_R, 1'b0, 1'b1);
        step(1'b0, T_R, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, T_R, 1'b0, 1'b1);
        step(1'b0, T_ST, 1'b0, 1'b1);
        step(1'b0, T_ST, 1'b0, 1'b1);
        step(1'b0, T_ST, 1'b0, 1'b1);
        step(1'b0, T_ST, 1'b0, 1'b0);
        step(1'b0, T_ST, 1'b0, 1'b0);
        check_val("wr_wait_memwrite", 32'(MemWrite), 32'd1);
        check_val("wr_wait_instret", 32'(instret), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_val("abort_memwrite", 32'(MemWrite), 32'd0);
        check_val("abort_wen", 32'({PCWrite, IRWrite, RegWrite}), 32'd0);
        check_val("abort_state", 32'(state_o), 32'(ST_RESET));
        check_val("abort_instret", 32'(instret), 32'd0);
        step(1'b1, T_R, 1'b0, 1'b1);

        // instret wrap: 2^CW R-type instructions bring it back to zero
        step(1'b0, T_R, 1'b0, 1'b1);
        for (int i = 0; i < 4 * (1 << CW); i++) step(1'b0, T_R, 1'b0, 1'b1);
        step(1'b0, T_R, 1'b0, 1'b1);
        check_val("wrap_state", 32'(state_o), 32'(ST_FETCH));
        check_val("wrap_instret", 32'(instret), 32'd0);

        // Randomized traffic against the model
        cur_op = T_R;
        for (int i = 0; i < 1500; i++) begin
            r_rst = (m_st == ST_ERROR) || ($urandom_range(0, 299) == 0);
            if (m_st == ST_FETCH || m_st == ST_RESET) begin
                case ($urandom_range(0, 8))
                    0: cur_op = T_R;
                    1: cur_op = T_I;
                    2: cur_op = T_LD;
                    3: cur_op = T_ST;
                    4: cur_op = T_BR;
                    5: cur_op = T_JAL;
                    6: cur_op = T_LUI;
                    default: cur_op = 7'($urandom);
                endcase
            end
            r_bt = 1'($urandom_range(0, 1));
            r_mr = ($urandom_range(0, 9) < 7);
            step(r_rst, cur_op, r_bt, r_mr);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
